e6_trace_monitor: RTL and testbench

Receive-side checker for the e6 controller's 20-bit output word. Each valid output word is decoded into the state transition that produced it. The block tracks the controller's present state from the outputs alone, flags words that are illegal for the tracked state, and counts transitions and errors. It sits on the observation side of a locked or unlocked e6 instance and is the reader counterpart of the e6 output encoder.

---
 rtl/e6_trace_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_e6_trace_monitor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e6_trace_monitor.sv
// e6_trace_monitor: decodes each valid 20-bit e6 output word back into the
//   state transition that produced it. It tracks the controller's state,
//   flags illegal words, and keeps saturating transition and error counters.
// Latency: 1 cycle from a sampled word to state_est, counters and err_pulse.
//   locked is decoded combinationally from the state register.
// Backpressure: none. A valid word is accepted on every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset. Returns the monitor to s1.
//   y_in       e6 output word; bit k-1 carries yk
//   y_valid    y_in carries one controller step this cycle
//   err_clr    clears err_sticky and err_cnt
//   state_est  tracked state: 1..11 = s1..s11, 0 = LOST
//   locked     state_est != LOST
//   err_pulse  one-cycle strobe on an illegal word
//   err_sticky latched error flag
//   trans_cnt  saturating count of accepted state-changing words
//   err_cnt    saturating count of illegal words
module e6_trace_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [19:0]      y_in,
  input  logic             y_valid,
  input  logic             err_clr,
  output logic [3:0]       state_est,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [3:0] {
    ST_LOST = 4'd0,
    ST_S1   = 4'd1,
    ST_S2   = 4'd2,
    ST_S3   = 4'd3,
    ST_S4   = 4'd4,
    ST_S5   = 4'd5,
    ST_S6   = 4'd6,
    ST_S7   = 4'd7,
    ST_S8   = 4'd8,
    ST_S9   = 4'd9,
    ST_S10  = 4'd10,
    ST_S11  = 4'd11
  } state_e;

  typedef enum logic [4:0] {
    PAT_A, PAT_B, PAT_C, PAT_D, PAT_E, PAT_F, PAT_G, PAT_H, PAT_I,
    PAT_J, PAT_K, PAT_L, PAT_M, PAT_N, PAT_O, PAT_P, PAT_Q,
    PAT_Z, PAT_UNK
  } pat_e;

  // Exact output words, bit k-1 = yk. Every bit not listed must be 0.
  localparam logic [19:0] W_A = 20'h40000; // y19
  localparam logic [19:0] W_B = 20'h08000; // y16
  localparam logic [19:0] W_C = 20'h00181; // y1 y8 y9
  localparam logic [19:0] W_D = 20'h00007; // y1 y2 y3
  localparam logic [19:0] W_E = 20'h00803; // y1 y2 y12
  localparam logic [19:0] W_F = 20'h00C01; // y1 y11 y12
  localparam logic [19:0] W_G = 20'h04140; // y7 y9 y15
  localparam logic [19:0] W_H = 20'h06101; // y1 y9 y14 y15
  localparam logic [19:0] W_I = 20'h00A02; // y2 y10 y12
  localparam logic [19:0] W_J = 20'h00E00; // y10 y11 y12
  localparam logic [19:0] W_K = 20'h10180; // y8 y9 y17
  localparam logic [19:0] W_L = 20'h00010; // y5
  localparam logic [19:0] W_M = 20'h80000; // y20
  localparam logic [19:0] W_N = 20'h00020; // y6
  localparam logic [19:0] W_O = 20'h01000; // y13
  localparam logic [19:0] W_P = 20'h00008; // y4
  localparam logic [19:0] W_Q = 20'h20000; // y18
  localparam logic [19:0] W_Z = 20'h00000;

  state_e          state_q, state_d;
  logic            pulse_q, pulse_d;
  logic            sticky_q, sticky_d;
  logic [CNT_W-1:0] trans_q, trans_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  pat_e pat;
  logic pat_moves;

  // Counter increment that holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // State the controller enters after emitting a given pattern.
  function automatic state_e pat_next(input pat_e p);
    state_e s;
    s = ST_LOST;
    case (p)
      PAT_A, PAT_B:        s = ST_S2;
      PAT_C:               s = ST_S3;
      PAT_D:               s = ST_S4;
      PAT_E, PAT_F:        s = ST_S5;
      PAT_G, PAT_H:        s = ST_S6;
      PAT_I, PAT_J:        s = ST_S7;
      PAT_K:               s = ST_S8;
      PAT_L:               s = ST_S9;
      PAT_M, PAT_N, PAT_O: s = ST_S10;
      PAT_P:               s = ST_S11;
      PAT_Q:               s = ST_S1;
      default:             s = ST_LOST;
    endcase
    return s;
  endfunction

  // Words the controller can legally emit from each tracked state.
  // s1, s2, s9, s10 and s11 always move, so Z is illegal there.
  function automatic logic pat_legal(input state_e s, input pat_e p);
    logic ok;
    ok = 1'b0;
    case (s)
      ST_S1:  ok = p inside {PAT_A, PAT_B, PAT_C, PAT_D, PAT_E, PAT_G, PAT_I};
      ST_S2:  ok = (p == PAT_K);
      ST_S3:  ok = p inside {PAT_L, PAT_F, PAT_M, PAT_J, PAT_Z};
      ST_S4:  ok = p inside {PAT_P, PAT_Z};
      ST_S5:  ok = p inside {PAT_N, PAT_Z};
      ST_S6:  ok = p inside {PAT_B, PAT_Z};
      ST_S7:  ok = p inside {PAT_H, PAT_O, PAT_Z};
      ST_S8:  ok = p inside {PAT_Q, PAT_Z};
      ST_S9:  ok = p inside {PAT_A, PAT_C, PAT_E, PAT_G, PAT_I};
      ST_S10: ok = (p == PAT_B);
      ST_S11: ok = p inside {PAT_A, PAT_C, PAT_G, PAT_I};
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Exact-match pattern decode.
  always_comb begin
    pat = PAT_UNK;
    case (y_in)
      W_A: pat = PAT_A;
      W_B: pat = PAT_B;
      W_C: pat = PAT_C;
      W_D: pat = PAT_D;
      W_E: pat = PAT_E;
      W_F: pat = PAT_F;
      W_G: pat = PAT_G;
      W_H: pat = PAT_H;
      W_I: pat = PAT_I;
      W_J: pat = PAT_J;
      W_K: pat = PAT_K;
      W_L: pat = PAT_L;
      W_M: pat = PAT_M;
      W_N: pat = PAT_N;
      W_O: pat = PAT_O;
      W_P: pat = PAT_P;
      W_Q: pat = PAT_Q;
      W_Z: pat = PAT_Z;
      default: pat = PAT_UNK;
    endcase
  end

  // A known, non-dwell pattern changes the state.
  assign pat_moves = (pat != PAT_UNK) && (pat != PAT_Z);

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    trans_d  = trans_q;
    errc_d   = errc_q;
    sticky_d = sticky_q;
    pulse_d  = 1'b0;

    // The clear is applied first so that an illegal word in the same cycle
    // re-sets the flag and restarts the error count at 1.
    if (err_clr) begin
      sticky_d = 1'b0;
      errc_d   = '0;
    end

    if (y_valid) begin
      if (state_q == ST_LOST) begin
        // Resync: any moving pattern identifies the next state directly.
        // Z and unknown words carry no state information here.
        if (pat_moves) begin
          state_d = pat_next(pat);
          trans_d = sat_inc(trans_q);
        end
      end else if (pat_legal(state_q, pat)) begin
        if (pat_moves) begin
          state_d = pat_next(pat);
          trans_d = sat_inc(trans_q);
        end
      end else begin
        pulse_d  = 1'b1;
        sticky_d = 1'b1;
        errc_d   = sat_inc(errc_d);
        state_d  = ST_LOST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_S1;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      trans_q  <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      trans_q  <= trans_d;
      errc_q   <= errc_d;
    end
  end

  assign state_est  = state_q;
  assign locked     = (state_q != ST_LOST);
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign trans_cnt  = trans_q;
  assign err_cnt    = errc_q;

endmodule

// File: tb/tb_e6_trace_monitor.sv
// tb_e6_trace_monitor: self-checking bench for e6_trace_monitor.
// Runs a 16-bit and a 4-bit counter instance on identical stimulus.
// A letter/string-based model predicts every cycle.
module tb_e6_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        y_valid;
  logic        err_clr;
  logic [19:0] y_in;

  logic [3:0]  st16, st4;
  logic        lk16, lk4, ep16, ep4, es16, es4;
  logic [15:0] tc16, ec16;
  logic [3:0]  tc4, ec4;

  always #5 clk = ~clk;

  e6_trace_monitor #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .err_clr(err_clr),
    .state_est(st16), .locked(lk16), .err_pulse(ep16), .err_sticky(es16),
    .trans_cnt(tc16), .err_cnt(ec16)
  );

  e6_trace_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .err_clr(err_clr),
    .state_est(st4), .locked(lk4), .err_pulse(ep4), .err_sticky(es4),
    .trans_cnt(tc4), .err_cnt(ec4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the words and their next states, indexed by letter A..Q,
  // plus a string of legal letters for each state.
  logic [19:0] pw [0:16];
  int          pn [0:16];
  string       legal [0:11];

  int m_st, m_tr16, m_tr4, m_er16, m_er4;
  bit m_sticky, m_pulse;

  // Builds a word from the 1-based y indices that are set.
  function automatic logic [19:0] yb(int a, int b = 0, int c = 0, int d = 0);
    logic [19:0] w;
    w = '0;
    if (a > 0) w[a-1] = 1'b1;
    if (b > 0) w[b-1] = 1'b1;
    if (c > 0) w[c-1] = 1'b1;
    if (d > 0) w[d-1] = 1'b1;
    return w;
  endfunction

  function automatic logic [19:0] wd(byte letter);
    return pw[int'(letter) - 65];
  endfunction

  function automatic bit has_letter(string s, byte c);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Returns 0..16 for A..Q, 17 for Z, -1 for an unknown word.
  function automatic int classify(logic [19:0] y);
    if (y == 20'h0) return 17;
    for (int i = 0; i < 17; i++)
      if (pw[i] == y) return i;
    return -1;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  task automatic model_step(bit r, bit v, logic [19:0] y, bit c);
    int  k;
    byte letter;
    if (r) begin
      m_st = 1; m_tr16 = 0; m_tr4 = 0; m_er16 = 0; m_er4 = 0;
      m_sticky = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (c) begin
      m_sticky = 0; m_er16 = 0; m_er4 = 0;
    end
    if (!v) return;
    k = classify(y);
    if (m_st == 0) begin
      if (k >= 0 && k < 17) begin
        m_st = pn[k];
        m_tr16 = sat(m_tr16, 65535);
        m_tr4 = sat(m_tr4, 15);
      end
    end else begin
      letter = (k < 0) ? 8'd63 : (k == 17) ? 8'd90 : 8'(65 + k);
      if (k >= 0 && has_letter(legal[m_st], letter)) begin
        if (k < 17) begin
          m_st = pn[k];
          m_tr16 = sat(m_tr16, 65535);
          m_tr4 = sat(m_tr4, 15);
        end
      end else begin
        m_pulse = 1; m_sticky = 1; m_st = 0;
        m_er16 = sat(m_er16, 65535);
        m_er4 = sat(m_er4, 15);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the
  // rising edge, and compare both instances against the model.
  task automatic step(bit r, bit v, logic [19:0] y, bit c);
    @(negedge clk);
    rst = r; y_valid = v; y_in = y; err_clr = c;
    model_step(r, v, y, c);
    @(posedge clk);
    #1;
    chk("m_state16", st16, m_st);
    chk("m_locked16", lk16, m_st != 0);
    chk("m_pulse16", ep16, m_pulse);
    chk("m_sticky16", es16, m_sticky);
    chk("m_trans16", tc16, m_tr16);
    chk("m_err16", ec16, m_er16);
    chk("m_state4", st4, m_st);
    chk("m_pulse4", ep4, m_pulse);
    chk("m_trans4", tc4, m_tr4);
    chk("m_err4", ec4, m_er4);
  endtask

  typedef struct {
    bit          r;
    logic [19:0] y;
    int          exp_st;
    int          exp_tr;
  } vec_t;

  vec_t tbl [0:5];

  initial begin
    int    sel;
    byte   letter;
    string ls;

    pw[0]  = yb(19);          pn[0]  = 2;   // A
    pw[1]  = yb(16);          pn[1]  = 2;   // B
    pw[2]  = yb(1, 8, 9);     pn[2]  = 3;   // C
    pw[3]  = yb(1, 2, 3);     pn[3]  = 4;   // D
    pw[4]  = yb(1, 2, 12);    pn[4]  = 5;   // E
    pw[5]  = yb(1, 11, 12);   pn[5]  = 5;   // F
    pw[6]  = yb(7, 9, 15);    pn[6]  = 6;   // G
    pw[7]  = yb(1, 9, 14, 15); pn[7] = 6;   // H
    pw[8]  = yb(2, 10, 12);   pn[8]  = 7;   // I
    pw[9]  = yb(10, 11, 12);  pn[9]  = 7;   // J
    pw[10] = yb(8, 9, 17);    pn[10] = 8;   // K
    pw[11] = yb(5);           pn[11] = 9;   // L
    pw[12] = yb(20);          pn[12] = 10;  // M
    pw[13] = yb(6);           pn[13] = 10;  // N
    pw[14] = yb(13);          pn[14] = 10;  // O
    pw[15] = yb(4);           pn[15] = 11;  // P
    pw[16] = yb(18);          pn[16] = 1;   // Q

    legal[0]  = "";
    legal[1]  = "ABCDEGI";
    legal[2]  = "K";
    legal[3]  = "LFMJZ";
    legal[4]  = "PZ";
    legal[5]  = "NZ";
    legal[6]  = "BZ";
    legal[7]  = "HOZ";
    legal[8]  = "QZ";
    legal[9]  = "ACEGI";
    legal[10] = "B";
    legal[11] = "ACGI";

    m_st = 1; m_tr16 = 0; m_tr4 = 0; m_er16 = 0; m_er4 = 0;
    m_sticky = 0; m_pulse = 0;
    rst = 1'b1; y_valid = 1'b0; y_in = '0; err_clr = 1'b0;

    // Nominal path: reset, then C L A K Q.
    tbl[0] = '{1'b1, wd("C"), 1, 0};  // word during reset is discarded
    tbl[1] = '{1'b0, wd("C"), 3, 1};
    tbl[2] = '{1'b0, wd("L"), 9, 2};
    tbl[3] = '{1'b0, wd("A"), 2, 3};
    tbl[4] = '{1'b0, wd("K"), 8, 4};
    tbl[5] = '{1'b0, wd("Q"), 1, 5};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].r, 1'b1, tbl[i].y, 1'b0);
      chk("nom_state", st16, tbl[i].exp_st);
      chk("nom_trans", tc16, tbl[i].exp_tr);
      chk("nom_sticky", es16, 0);
    end
    chk("nom_locked", lk16, 1);
    chk("nom_err_cnt", ec16, 0);

    // Dwell in s4 for three Z words, then leave on P.
    step(1, 0, '0, 0);
    step(0, 1, wd("D"), 0);
    chk("dwell_s4", st16, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 20'h0, 0);
      chk("dwell_hold", st16, 4);
      chk("dwell_trans", tc16, 1);
      chk("dwell_pulse", ep16, 0);
    end
    step(0, 1, wd("P"), 0);
    chk("dwell_exit", st16, 11);
    chk("dwell_trans2", tc16, 2);
    chk("dwell_sticky", es16, 0);

    // Illegal Z in s2, unknown word while LOST, resync on I.
    step(1, 0, '0, 0);
    step(0, 1, wd("A"), 0);
    chk("ill_s2", st16, 2);
    step(0, 1, 20'h0, 0);
    chk("ill_pulse", ep16, 1);
    chk("ill_state", st16, 0);
    chk("ill_locked", lk16, 0);
    chk("ill_err_cnt", ec16, 1);
    step(0, 1, 20'hFFFFF, 0);
    chk("lost_unk_state", st16, 0);
    chk("lost_unk_err", ec16, 1);
    chk("lost_unk_pulse", ep16, 0);
    step(0, 1, wd("I"), 0);
    chk("resync_state", st16, 7);
    chk("resync_locked", lk16, 1);
    chk("resync_trans", tc16, 2);

    // Five idle cycles with garbage on y_in: everything holds.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 20'($urandom), 0);
      chk("gap_state", st16, 7);
      chk("gap_trans", tc16, 2);
      chk("gap_sticky", es16, 1);
      chk("gap_pulse", ep16, 0);
    end
    // Clear coinciding with an illegal word (A in s7): error wins.
    step(0, 1, wd("A"), 1);
    chk("clr_ill_sticky", es16, 1);
    chk("clr_ill_err", ec16, 1);
    chk("clr_ill_state", st16, 0);
    step(0, 0, '0, 1);
    chk("clr_sticky", es16, 0);
    chk("clr_err", ec16, 0);

    // Saturation: 20 legal moving words; the 4-bit counter stops at 15.
    step(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, wd("C"), 0);
      step(0, 1, wd("L"), 0);
      step(0, 1, wd("A"), 0);
      step(0, 1, wd("K"), 0);
      step(0, 1, wd("Q"), 0);
    end
    chk("sat_trans4", tc4, 15);
    chk("sat_trans16", tc16, 20);
    chk("sat_err4", ec4, 0);

    // Reset mid-operation in s7 with H presented.
    step(1, 0, '0, 0);
    step(0, 1, wd("I"), 0);
    chk("rmid_s7", st16, 7);
    step(1, 1, wd("H"), 0);
    chk("rmid_state", st16, 1);
    chk("rmid_trans", tc16, 0);
    chk("rmid_err", ec16, 0);
    chk("rmid_pulse", ep16, 0);
    step(0, 1, wd("C"), 0);
    chk("rmid_next", st16, 3);

    // Random traffic biased towards legal walks, compared each cycle.
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 65 && m_st != 0) begin
        ls = legal[m_st];
        letter = ls[int'($urandom_range(0, ls.len() - 1))];
        y_in = (letter == 8'd90) ? 20'h0 : wd(letter);
      end else if (sel < 82) begin
        y_in = pw[$urandom_range(0, 16)];
      end else if (sel < 90) begin
        y_in = 20'h0;
      end else begin
        y_in = 20'($urandom);
      end
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 85,
           y_in, $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
